// File: rtl/branch_predictor.sv
// Fetch-side BTB predictor with 2-bit saturating counters, plus execute-side resolution,
// mispredict redirect and a saturating mispredict counter.
module branch_predictor #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned INDEX_BITS = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [ADDR_WIDTH-1:0] i_PCF,
  input  logic                  i_stall,
  input  logic                  i_flushD,
  input  logic                  i_flushE,
  input  logic                  i_BranchE,
  input  logic                  i_TakenE,
  input  logic [ADDR_WIDTH-1:0] i_PCE,
  input  logic [ADDR_WIDTH-1:0] i_TargetE,
  input  logic [ADDR_WIDTH-1:0] i_PCPlus4E,
  output logic                  o_PredTakenF,
  output logic [ADDR_WIDTH-1:0] o_PredTargetF,
  output logic                  o_flushBranch,
  output logic [ADDR_WIDTH-1:0] o_PCCorrectE,
  output logic [CNT_WIDTH-1:0]  o_mispredCount
);

  localparam int unsigned Entries = 2 ** INDEX_BITS;
  localparam int unsigned TagW    = ADDR_WIDTH - INDEX_BITS - 2;

  logic                  r_valid  [Entries];
  logic [TagW-1:0]       r_tag    [Entries];
  logic [ADDR_WIDTH-1:0] r_target [Entries];
  logic [1:0]            r_cnt    [Entries];

  logic                  r_pred_taken_d;
  logic [ADDR_WIDTH-1:0] r_pred_target_d;
  logic                  r_pred_taken_e;
  logic [ADDR_WIDTH-1:0] r_pred_target_e;
  logic [CNT_WIDTH-1:0]  r_mispred_cnt;

  logic [INDEX_BITS-1:0] w_idx_f;
  logic [TagW-1:0]       w_tag_f;
  logic                  w_hit_f;
  logic [INDEX_BITS-1:0] w_idx_e;
  logic [TagW-1:0]       w_tag_e;
  logic                  w_hit_e;
  logic                  w_flush;

  assign w_idx_f = i_PCF[INDEX_BITS+1:2];
  assign w_tag_f = i_PCF[ADDR_WIDTH-1:INDEX_BITS+2];
  assign w_hit_f = r_valid[w_idx_f] && (r_tag[w_idx_f] == w_tag_f);

  assign w_idx_e = i_PCE[INDEX_BITS+1:2];
  assign w_tag_e = i_PCE[ADDR_WIDTH-1:INDEX_BITS+2];
  assign w_hit_e = r_valid[w_idx_e] && (r_tag[w_idx_e] == w_tag_e);

  // Lookup reads the registered table, so a same-cycle update is not visible to F.
  always_comb begin
    o_PredTakenF  = w_hit_f && r_cnt[w_idx_f][1];
    o_PredTargetF = '0;
    if (o_PredTakenF) o_PredTargetF = r_target[w_idx_f];
  end

  assign w_flush = i_BranchE &&
                   ((r_pred_taken_e != i_TakenE) ||
                    (i_TakenE && (r_pred_target_e != i_TargetE)));

  assign o_flushBranch  = w_flush;
  assign o_PCCorrectE   = i_TakenE ? i_TargetE : i_PCPlus4E;
  assign o_mispredCount = r_mispred_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < Entries; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_cnt[i]    <= 2'b01;
      end
    end else if (i_BranchE) begin
      if (w_hit_e) begin
        if (i_TakenE) begin
          if (r_cnt[w_idx_e] != 2'b11) r_cnt[w_idx_e] <= r_cnt[w_idx_e] + 2'd1;
          r_target[w_idx_e] <= i_TargetE;
        end else if (r_cnt[w_idx_e] != 2'b00) begin
          r_cnt[w_idx_e] <= r_cnt[w_idx_e] - 2'd1;
        end
      end else if (i_TakenE) begin
        // Allocation evicts whatever alias occupied this index.
        r_valid[w_idx_e]  <= 1'b1;
        r_tag[w_idx_e]    <= w_tag_e;
        r_target[w_idx_e] <= i_TargetE;
        r_cnt[w_idx_e]    <= 2'b10;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pred_taken_d  <= 1'b0;
      r_pred_target_d <= '0;
      r_pred_taken_e  <= 1'b0;
      r_pred_target_e <= '0;
    end else begin
      if (i_flushD) begin
        r_pred_taken_d  <= 1'b0;
        r_pred_target_d <= '0;
      end else if (!i_stall) begin
        r_pred_taken_d  <= o_PredTakenF;
        r_pred_target_d <= o_PredTargetF;
      end
      if (i_flushE) begin
        r_pred_taken_e  <= 1'b0;
        r_pred_target_e <= '0;
      end else begin
        r_pred_taken_e  <= r_pred_taken_d;
        r_pred_target_e <= r_pred_target_d;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mispred_cnt <= '0;
    end else if (w_flush && (r_mispred_cnt != '1)) begin
      r_mispred_cnt <= r_mispred_cnt + CNT_WIDTH'(1);
    end
  end

endmodule
